// File: rtl/mii_pkg.sv
// mii_pkg: shared types and constants for the MII transmit framer.
//   tx_state_t      framer state encoding
//   PREAMBLE_*/SFD_NIBBLE  line symbols for the frame start
//   CRC_*           reflected CRC-32 constants (Ethernet FCS)
//   sat_inc11       saturating increment for the 11-bit byte counter
package mii_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    DROP,
    IPG
  } tx_state_t;

  localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
  localparam int          PREAMBLE_CYCLES = 15;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  // Bit-reversed form of 0x04C11DB7; data enters LSB first.
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/mii_tx_framer_if.sv
// mii_tx_framer_if: byte stream from the MAC TX path into the framer.
//   s_data  frame byte
//   s_valid s_data valid
//   s_last  final byte of the frame
//   s_ready byte accepted when s_valid && s_ready
// master = byte source, slave = framer.
interface mii_tx_framer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/crc32.sv
// crc32: one combinational nibble step of the reflected Ethernet CRC-32.
//   crc      current CRC register
//   din      nibble being transmitted (bit 0 goes on the wire first)
//   crc_next CRC register after absorbing din
module crc32
  import mii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  din,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 4; i++)
      crc_next = (crc_next >> 1) ^ ((crc_next[0] ^ din[i]) ? CRC_POLY : 32'h0);
  end

endmodule

// File: rtl/mii_tx_framer.sv
// mii_tx_framer: Ethernet MII transmit framer.
// Emits preamble + SFD, payload low nibble first, optional zero pad up to
// MIN_BYTES, then the FCS; an input stall mid-frame aborts with txer and the
// rest of the frame is drained. An inter-packet gap follows every frame.
//   clk, rst      MII TX clock, synchronous active-high reset
//   s             byte stream (mii_tx_framer_if.slave)
//   mii_txd/txen/txer  MII transmit pins (registered)
//   busy          high whenever the framer is not idle
//   underrun      one-cycle pulse on frame abort
// Build option: define MII_TX_PAD_EN to zero-pad short frames to MIN_BYTES;
// without it the FCS directly follows the last data byte.
module mii_tx_framer
  import mii_pkg::*;
#(
  parameter int IPG_BYTES = 12,
  parameter int MIN_BYTES = 60
) (
  input  logic           clk,
  input  logic           rst,
  mii_tx_framer_if.slave s,
  output logic [3:0]     mii_txd,
  output logic           mii_txen,
  output logic           mii_txer,
  output logic           busy,
  output logic           underrun
);

  localparam int IPG_CYCLES = 2 * IPG_BYTES;
  localparam int IPG_W      = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;

  tx_state_t        state;
  logic [3:0]       pre_cnt;
  logic [IPG_W-1:0] ipg_cnt;
  logic [2:0]       fcs_idx, fcs_nxt;
  logic             hi;       // current output nibble is the high half
  logic [3:0]       hi_nib;   // high nibble of the byte on the wire
  logic             last_q;   // byte on the wire carried s_last
  logic [31:0]      crc, crc_next;
  logic [3:0]       crc_nib;
`ifdef MII_TX_PAD_EN
  logic [10:0]      byte_cnt;
`endif

  assign fcs_nxt = fcs_idx + 3'd1;

  // The CRC absorbs whichever nibble is being loaded into mii_txd this edge.
  // In the last byte's high-nibble cycle that is a pad zero, not s_data.
  always_comb begin
    crc_nib = 4'h0;
    if (state == DATA && !hi)
      crc_nib = hi_nib;
    else if (state == SFD || (state == DATA && !last_q))
      crc_nib = s.s_data[3:0];
  end

  crc32 u_crc (
    .crc      (crc),
    .din      (crc_nib),
    .crc_next (crc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mii_txd   <= 4'h0;
      mii_txen  <= 1'b0;
      mii_txer  <= 1'b0;
      s.s_ready <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      pre_cnt   <= 4'd0;
      ipg_cnt   <= '0;
      fcs_idx   <= 3'd0;
      hi        <= 1'b0;
      hi_nib    <= 4'h0;
      last_q    <= 1'b0;
      crc       <= 32'h0;
`ifdef MII_TX_PAD_EN
      byte_cnt  <= 11'd0;
`endif
    end else begin
      underrun <= 1'b0;
      mii_txer <= 1'b0;
      case (state)
        IDLE: begin
          if (s.s_valid) begin
            state    <= PREAMBLE;
            busy     <= 1'b1;
            mii_txen <= 1'b1;
            mii_txd  <= PREAMBLE_NIBBLE;
            pre_cnt  <= 4'd1;
          end
        end

        PREAMBLE: begin
          if (pre_cnt == 4'(PREAMBLE_CYCLES)) begin
            state     <= SFD;
            mii_txd   <= SFD_NIBBLE;
            s.s_ready <= 1'b1;
            crc       <= CRC_INIT;
`ifdef MII_TX_PAD_EN
            byte_cnt  <= 11'd0;
`endif
          end else begin
            pre_cnt <= pre_cnt + 4'd1;
          end
        end

        // SFD and the high-nibble DATA cycle share the byte handshake.
        SFD, DATA: begin
          if (state == DATA && !hi) begin
            hi        <= 1'b1;
            mii_txd   <= hi_nib;
            crc       <= crc_next;
            s.s_ready <= !last_q;
          end else if (s.s_ready && s.s_valid) begin
            state     <= DATA;
            hi        <= 1'b0;
            hi_nib    <= s.s_data[7:4];
            last_q    <= s.s_last;
            mii_txd   <= s.s_data[3:0];
            crc       <= crc_next;
            s.s_ready <= 1'b0;
`ifdef MII_TX_PAD_EN
            byte_cnt  <= sat_inc11(byte_cnt);
`endif
          end else if (state == DATA && last_q) begin
`ifdef MII_TX_PAD_EN
            if (byte_cnt < 11'(MIN_BYTES)) begin
              state    <= PAD;
              hi       <= 1'b0;
              mii_txd  <= 4'h0;
              crc      <= crc_next;
              byte_cnt <= sat_inc11(byte_cnt);
            end else begin
              state   <= FCS;
              mii_txd <= ~crc[3:0];
              fcs_idx <= 3'd0;
            end
`else
            state   <= FCS;
            mii_txd <= ~crc[3:0];
            fcs_idx <= 3'd0;
`endif
          end else begin
            // Source starved mid-frame: flag the error and drain the rest.
            state     <= DROP;
            mii_txd   <= 4'h0;
            mii_txer  <= 1'b1;
            underrun  <= 1'b1;
            s.s_ready <= 1'b1;
          end
        end

`ifdef MII_TX_PAD_EN
        // byte_cnt is bumped as each pad byte starts.
        PAD: begin
          if (!hi) begin
            hi      <= 1'b1;
            mii_txd <= 4'h0;
            crc     <= crc_next;
          end else if (byte_cnt < 11'(MIN_BYTES)) begin
            hi       <= 1'b0;
            mii_txd  <= 4'h0;
            crc      <= crc_next;
            byte_cnt <= sat_inc11(byte_cnt);
          end else begin
            state   <= FCS;
            mii_txd <= ~crc[3:0];
            fcs_idx <= 3'd0;
          end
        end
`endif

        // crc is held; fcs_idx is the nibble currently on the wire.
        FCS: begin
          if (fcs_idx == 3'd7) begin
            state    <= IPG;
            mii_txen <= 1'b0;
            mii_txd  <= 4'h0;
            ipg_cnt  <= IPG_W'(1);
          end else begin
            fcs_idx <= fcs_nxt;
            mii_txd <= ~crc[{fcs_nxt, 2'b00} +: 4];
          end
        end

        DROP: begin
          mii_txen <= 1'b0;
          mii_txd  <= 4'h0;
          if (s.s_valid && s.s_last) begin
            state     <= IPG;
            s.s_ready <= 1'b0;
            ipg_cnt   <= IPG_W'(1);
          end
        end

        // The IDLE cycle that samples s_valid completes the gap, so IPG
        // itself lasts one cycle less than 2*IPG_BYTES.
        IPG: begin
          if (ipg_cnt >= IPG_W'(IPG_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ipg_cnt <= ipg_cnt + IPG_W'(1);
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          mii_txen  <= 1'b0;
          s.s_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_framer.sv
// tb_mii_tx_framer: self-checking bench for mii_tx_framer.
// Expected nibble streams ({underrun, txer, txd} per txen cycle) are queued
// when a frame is driven and compared when the DUT finishes the frame.
module tb_mii_tx_framer;

  localparam int IPG_BYTES = 12;
  localparam int MIN_BYTES = 60;
`ifdef MII_TX_PAD_EN
  localparam int SHORT9 = 144;
  localparam int SHORT1 = 144;
`else
  localparam int SHORT9 = 42;
  localparam int SHORT1 = 26;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mii_txd;
  logic       mii_txen, mii_txer, busy, underrun;

  mii_tx_framer_if sif ();

  mii_tx_framer #(.IPG_BYTES(IPG_BYTES), .MIN_BYTES(MIN_BYTES)) dut (
    .clk      (clk),
    .rst      (rst),
    .s        (sif),
    .mii_txd  (mii_txd),
    .mii_txen (mii_txen),
    .mii_txer (mii_txer),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [7:0] fb[$];          // frame bytes being driven
  logic [5:0] exp_items[$];
  int         exp_len[$];
  int         accepted = 0;

  function automatic void push_expected(input int ua);
    logic [31:0] c;
    int nb, n;
    c = 32'hFFFFFFFF;
    n = 0;
    for (int i = 0; i < 15; i++) begin exp_items.push_back(6'h05); n++; end
    exp_items.push_back(6'h0D); n++;
    nb = (ua >= 0) ? ua : fb.size();
    for (int i = 0; i < nb; i++) begin
      exp_items.push_back({2'b00, fb[i][3:0]});
      exp_items.push_back({2'b00, fb[i][7:4]});
      c = crc_byte(c, fb[i]);
      n += 2;
    end
    if (ua >= 0) begin
      exp_items.push_back(6'h30); n++;
    end else begin
`ifdef MII_TX_PAD_EN
      for (int i = nb; i < MIN_BYTES; i++) begin
        exp_items.push_back(6'h00);
        exp_items.push_back(6'h00);
        c = crc_byte(c, 8'h00);
        n += 2;
      end
`endif
      c = ~c;
      for (int k = 0; k < 8; k++) begin
        exp_items.push_back({2'b00, c[4*k +: 4]}); n++;
      end
    end
    exp_len.push_back(n);
  endfunction

  // ---------------- monitor ----------------
  logic [5:0] cap[$];
  logic [5:0] last_frame[$];
  int  frames_done = 0, cur_len = 0, last_len = 0, gap = 0, last_gap = 0;
  int  first_rdy = -1, gap_rdy = 0, busy_bad = 0;
  bit  in_frame = 0, mon_en = 1, prev_err = 0;

  task automatic end_frame();
    int n, mism;
    logic [5:0] e;
    last_len = cur_len;
    if (exp_len.size() == 0) begin
      chk("unexpected_frame", cur_len, 0);
    end else begin
      n = exp_len.pop_front();
      chk("frame_len", cur_len, n);
      mism = 0;
      for (int k = 0; k < n; k++) begin
        e = (exp_items.size() > 0) ? exp_items.pop_front() : 6'h3F;
        if (k >= cap.size() || cap[k] !== e) mism++;
      end
      chk("frame_data_mismatches", mism, 0);
    end
    chk("first_ready_at_sfd", first_rdy, 15);
    chk("busy_low_in_frame", busy_bad, 0);
    prev_err = (cap.size() > 0) && cap[cap.size()-1][4];
    last_frame = cap;
    frames_done++;
  endtask

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      in_frame = 0; gap = 0; gap_rdy = 0; prev_err = 0;
      cap.delete();
    end else if (mii_txen) begin
      if (!in_frame) begin
        in_frame = 1; cur_len = 0; first_rdy = -1; busy_bad = 0;
        cap.delete();
        last_gap = gap;
        if (!prev_err) chk("ready_low_in_gap", gap_rdy, 0);
      end
      cap.push_back({underrun, mii_txer, mii_txd});
      if (sif.s_ready && first_rdy < 0) first_rdy = cur_len;
      if (!busy) busy_bad++;
      cur_len++;
    end else begin
      if (in_frame) begin
        end_frame();
        in_frame = 0; gap = 0; gap_rdy = 0;
      end
      gap++;
      if (sif.s_ready) gap_rdy++;
    end
  end

  // ---------------- driver ----------------
  task automatic idle(input int n);
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic build(input int len, input logic [7:0] base);
    fb.delete();
    for (int i = 0; i < len; i++) fb.push_back(8'(base + 8'(i)));
  endtask

  task automatic send_frame(input int stall_at, input int stall_len);
    bit rdy;
    int n;
    for (int i = 0; i < fb.size(); i++) begin
      if (i == stall_at) begin
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
      end
      sif.s_data  = fb[i];
      sif.s_valid = 1'b1;
      sif.s_last  = (i == fb.size() - 1);
      n = 0; rdy = 0;
      while (!rdy && n < 400) begin
        @(negedge clk);
        rdy = sif.s_ready;
        @(posedge clk);
        n++;
      end
      #1;
      if (!rdy) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: byte %0d not accepted after %0d cycles", i, n);
        return;
      end
      accepted++;
    end
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_done < target && n < 6000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (frames_done < target) begin
      checks++; errors++;
      $display("FAIL frame_timeout: frames %0d expected %0d", frames_done, target);
    end
  endtask

  typedef struct {
    int         len;
    logic [7:0] base;
    int         exp_cycles;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   zeros;
    logic [31:0] fcs, res;

    vecs[0] = '{9,    8'h31, SHORT9};
    vecs[1] = '{1,    8'hAB, SHORT1};
    vecs[2] = '{60,   8'h00, 144};
    vecs[3] = '{61,   8'h80, 146};
    vecs[4] = '{64,   8'hF0, 152};
    vecs[5] = '{1600, 8'h07, 3224};

    sif.s_data = 8'h00; sif.s_valid = 1'b0; sif.s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_txd", mii_txd, 0);
    chk("reset_txen", mii_txen, 0);
    chk("reset_txer", mii_txer, 0);
    chk("reset_ready", sif.s_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_underrun", underrun, 0);
    @(posedge clk); #1;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      build(vecs[v].len, vecs[v].base);
      push_expected(-1);
      send_frame(-1, 0);
      idle(1);
      wait_frames(v + 1);
      chk("table_txen_cycles", last_len, vecs[v].exp_cycles);
      if (vecs[v].len == 9 && last_frame.size() >= 42) begin
        res = 32'hFFFFFFFF;
        for (int i = 16; i + 1 < last_frame.size(); i += 2)
          res = crc_byte(res, {last_frame[i+1][3:0], last_frame[i][3:0]});
        chk("residue_9byte", res, 32'hDEBB20E3);
`ifndef MII_TX_PAD_EN
        for (int k = 0; k < 8; k++) fcs[4*k +: 4] = last_frame[34 + k][3:0];
        chk("fcs_123456789", fcs, 32'hCBF43926);
`endif
      end
      if (vecs[v].len == 1 && last_frame.size() >= 26) begin
        chk("ab_low_nibble", last_frame[16], 6'h0B);
        chk("ab_high_nibble", last_frame[17], 6'h0A);
        res = 32'hFFFFFFFF;
        for (int i = 16; i + 1 < last_frame.size(); i += 2)
          res = crc_byte(res, {last_frame[i+1][3:0], last_frame[i][3:0]});
        chk("residue_ab", res, 32'hDEBB20E3);
`ifdef MII_TX_PAD_EN
        zeros = 0;
        for (int i = 18; i < 136 && i < last_frame.size(); i++)
          if (last_frame[i] == 6'h00) zeros++;
        chk("ab_pad_zero_nibbles", zeros, 118);
`endif
      end
      idle(30);
    end

    // Back-to-back 64-byte frames with s_valid held high
    build(64, 8'h10); push_expected(-1);
    send_frame(-1, 0);
    build(64, 8'h90); push_expected(-1);
    send_frame(-1, 0);
    idle(1);
    wait_frames(8);
    chk("b2b_ipg_zero_cycles", last_gap, 2 * IPG_BYTES);
    idle(30);

    // Underrun: s_valid dropped after byte 5 of 20, then drained
    build(20, 8'h40); push_expected(5);
    accepted = 0;
    send_frame(5, 30);
    chk("underrun_bytes_drained", accepted, 20);
    build(12, 8'hC0); push_expected(-1);
    send_frame(-1, 0);
    idle(1);
    wait_frames(10);
    chk("post_underrun_gap_min", (last_gap >= 2 * IPG_BYTES) ? 1 : 0, 1);
    idle(30);

    // Reset mid-DATA
    mon_en = 0;
    sif.s_data = 8'h55; sif.s_valid = 1'b1; sif.s_last = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_txen", mii_txen, 1);
    @(posedge clk); #1;
    rst = 1'b1; sif.s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_txen", mii_txen, 0);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", sif.s_ready, 0);
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    build(12, 8'h21); push_expected(-1);
    send_frame(-1, 0);
    idle(1);
    wait_frames(11);
    idle(30);

    chk("scoreboard_empty", exp_len.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
